mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single 16-bit memory bus (address, read/write strobes, data) between two requesters: port 0 is the CPU controller/datapath, port 1 is a DMA or peripheral master.
- Sequences each transfer through a small FSM with a configurable number of memory wait states.
- Round-robin arbitration; no requester starves.
- Sits between the CPU top level and the memory. The tristate data pin is resolved outside this block from mem_wdata/mem_oe.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- WAIT_STATES, 1, extra memory cycles per access; legal range 0..15

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 transfer request
- rd0  in  1  port 0 read command
- wr0  in  1  port 0 write command
- adr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- ack0  out  1  port 0 transfer complete, one-cycle pulse
- rdata0  out  DATA_W  port 0 read data, valid while ack0=1
- req1/rd1/wr1/adr1/wdata1/ack1/rdata1  same as port 0, for port 1
- gnt  out  2  one-hot current owner; 00 when idle
- busy  out  1  high in any state other than IDLE
- mem_adr  out  ADDR_W  memory address
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_oe  out  1  high while mem_wdata must drive the data pins
- mem_wdata  out  DATA_W  write data toward the memory
- mem_rdata  in  DATA_W  read data from the memory

Behaviour:
- Reset values: state=IDLE, gnt=00, busy=0, ack0=ack1=0, mem_rd=mem_wr=mem_oe=0, mem_adr=0, mem_wdata=0, rdata0=rdata1=0, last_owner=1.
- Reset asserted mid-transfer: the next edge forces all reset values. The aborted transfer is never acked.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Samples req0/req1. With none, stays in IDLE.
  - With one request, that port wins.
  - With both, the port not equal to last_owner wins.
  - On the next edge: latch the winner's adr, wdata, rd, wr into internal registers; set gnt; load the wait counter with WAIT_STATES; go to ACCESS.
- ACCESS:
  - Drives mem_adr and mem_wdata from the latched registers.
  - mem_rd=latched rd; mem_wr=latched wr; mem_oe=latched wr.
  - Lasts WAIT_STATES+1 cycles; the counter decrements each cycle.
  - On the final ACCESS cycle, mem_rdata is captured into the owner's rdata register. DONE follows.
- DONE:
  - Strobes and mem_oe are low.
  - ack of the owner is 1 for exactly one cycle; that port's rdata is valid.
  - last_owner is updated to the owner.
  - Next state is IDLE, where gnt returns to 00.
- Latency: request sampled in IDLE at cycle 0 -> ack at cycle WAIT_STATES+2. Throughput is one transfer per WAIT_STATES+3 cycles.
- Requester rules:
  - Hold req, rd, wr, adr, wdata stable from request until ack.
  - Drop req at the edge ending the ack cycle, unless a back-to-back transfer is intended.
  - Changes to inputs after IDLE sampling have no effect on the transfer in progress.
- Command corner cases:
  - rd=wr=1: treated as a write only (mem_rd stays 0).
  - rd=wr=0 with req=1: a null transfer. Full FSM sequence, no strobes, ack still pulses, rdata unchanged.
- A non-owner's ack stays 0 and its rdata holds its previous value.
- Arbitration decisions happen only in IDLE; a request arriving mid-transfer waits.
- mem_adr and mem_wdata hold their last values outside ACCESS.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- When defined: port 0 (CPU) always wins simultaneous requests; last_owner is unused and port 1 is served only when req0=0 in IDLE.
- When undefined: round-robin as described above.

Test Plan:
- Single read: WAIT_STATES=1; port 0 reads adr 0x0040, memory returns 0xBEEF -> mem_rd high for 2 cycles, ack0 at cycle 3, rdata0=0xBEEF, gnt=01 during cycles 1-3.
- Single write: port 1 writes 0x1234 to 0x00A0 -> mem_wr=mem_oe=1 and mem_adr=0x00A0 for 2 cycles, mem_wdata=0x1234, ack1 at cycle 3, ack0 stays 0.
- Contention: req0 and req1 held continuously, both reads, after reset -> grant order 0,1,0,1; each ack spaced 4 cycles apart. With ARB_FIXED_PRIO_EN defined -> port 0 served every time, ack1 never asserted.
- Corner commands: rd=wr=1 on port 0 -> write only, mem_rd never 1. req with rd=wr=0 -> ack pulse, no strobes, rdata0 unchanged.
- Reset mid-ACCESS: assert reset on the 1st ACCESS cycle of a write -> next edge gives mem_wr=0, gnt=00, busy=0, no ack. After release, a fresh request from port 0 wins (last_owner=1).
- Zero wait states: WAIT_STATES=0, port 0 read -> mem_rd high 1 cycle, ack0 at cycle 2.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter and transfer sequencer for the shared 16-bit memory bus.
// Define ARB_FIXED_PRIO_EN to make port 0 always win simultaneous requests.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              rd0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] adr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              rd1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_oe,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                win;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    adr_d        = adr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    win          = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
`ifdef ARB_FIXED_PRIO_EN
          win = !req0;
`else
          // On contention the port that did not own the bus last time wins
          win = (req0 && req1) ? !last_owner_q : !req0;
`endif
          owner_d = win;
          rd_d    = win ? rd1 : rd0;
          wr_d    = win ? wr1 : wr0;
          adr_d   = win ? adr1 : adr0;
          wdata_d = win ? wdata1 : wdata0;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Only genuine reads update the owner's read-data register
          if (rd_q && !wr_q) begin
            if (owner_q) rdata1_d = mem_rdata;
            else         rdata0_d = mem_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      adr_q        <= '0;
      wdata_q      <= '0;
      cnt_q        <= 4'd0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      adr_q        <= adr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Latched address/data only change on entry to ACCESS, so they hold outside it
  assign busy      = (state_q != IDLE);
  assign gnt       = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign mem_adr   = adr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = (state_q == ACCESS) && wr_q;
  assign mem_oe    = (state_q == ACCESS) && wr_q;
  assign mem_rd    = (state_q == ACCESS) && rd_q && !wr_q;
  assign ack0      = (state_q == DONE) && !owner_q;
  assign ack1      = (state_q == DONE) && owner_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: one instance with WAIT_STATES=1, one with WAIT_STATES=0.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 0, rd0 = 0, wr0 = 0, req1 = 0, rd1 = 0, wr1 = 0;
  logic [15:0] adr0 = 0, wdata0 = 0, adr1 = 0, wdata1 = 0;
  logic        ack0, ack1, busy, mem_rd, mem_wr, mem_oe;
  logic [15:0] rdata0, rdata1, mem_adr, mem_wdata, mem_rdata;
  logic [1:0]  gnt;

  logic        z_req0 = 0, z_rd0 = 0, z_wr0 = 0;
  logic [15:0] z_adr0 = 0, z_wdata0 = 0;
  logic        z_ack0, z_ack1, z_busy, z_mem_rd, z_mem_wr, z_mem_oe;
  logic [15:0] z_rdata0, z_rdata1, z_mem_adr, z_mem_wdata, z_mem_rdata;
  logic [1:0]  z_gnt;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int          port;
    logic [15:0] rdata;
  } exp_t;
  exp_t sb[$];

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'hA5A5);
  endfunction

  assign mem_rdata   = mem_fn(mem_adr);
  assign z_mem_rdata = mem_fn(z_mem_adr);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .rd0(rd0), .wr0(wr0), .adr0(adr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .rd1(rd1), .wr1(wr1), .adr1(adr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .gnt(gnt), .busy(busy), .mem_adr(mem_adr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_oe(mem_oe), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req0(z_req0), .rd0(z_rd0), .wr0(z_wr0), .adr0(z_adr0), .wdata0(z_wdata0), .ack0(z_ack0), .rdata0(z_rdata0),
    .req1(1'b0), .rd1(1'b0), .wr1(1'b0), .adr1(16'h0), .wdata1(16'h0), .ack1(z_ack1), .rdata1(z_rdata1),
    .gnt(z_gnt), .busy(z_busy), .mem_adr(z_mem_adr), .mem_rd(z_mem_rd), .mem_wr(z_mem_wr),
    .mem_oe(z_mem_oe), .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_run++;
    if ({gnt, busy, ack0, ack1, mem_rd, mem_wr, mem_oe} !== 9'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp 0", {gnt, busy, ack0, ack1, mem_rd, mem_wr, mem_oe});
    end
    n_run++;
    if ({mem_adr, mem_wdata, rdata0, rdata1} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data got %h exp 0", {mem_adr, mem_wdata, rdata0, rdata1});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    exp_t e;
    @(negedge clk);
    req0 = 1; rd0 = 1; wr0 = 0; adr0 = 16'h0040;
    sb.push_back('{0, 16'hBEEF});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_run++;
      if (mem_rd !== (k < 3)) begin n_fail++; $display("FAIL read_mem_rd k=%0d got %b exp %b", k, mem_rd, (k < 3)); end
      n_run++;
      if (gnt !== 2'b01) begin n_fail++; $display("FAIL read_gnt k=%0d got %b exp 01", k, gnt); end
      n_run++;
      if (ack0 !== (k == 3)) begin n_fail++; $display("FAIL read_ack0 k=%0d got %b exp %b", k, ack0, (k == 3)); end
      if (k == 3) begin
        n_run++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL read_sb empty queue"); end
        else begin
          e = sb.pop_front();
          if (rdata0 !== e.rdata) begin n_fail++; $display("FAIL read_rdata0 got %h exp %h", rdata0, e.rdata); end
        end
        req0 = 0; rd0 = 0;
      end
    end
    @(negedge clk);
    n_run++;
    if ({gnt, busy} !== 3'b000) begin n_fail++; $display("FAIL read_idle got %b exp 000", {gnt, busy}); end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    req1 = 1; wr1 = 1; rd1 = 0; adr1 = 16'h00A0; wdata1 = 16'h1234;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_run++;
      if ({mem_wr, mem_oe, mem_rd} !== {(k < 3), (k < 3), 1'b0}) begin
        n_fail++; $display("FAIL write_strobes k=%0d got %b exp %b", k, {mem_wr, mem_oe, mem_rd}, {(k < 3), (k < 3), 1'b0});
      end
      n_run++;
      if (mem_adr !== 16'h00A0 || mem_wdata !== 16'h1234) begin
        n_fail++; $display("FAIL write_bus k=%0d got %h/%h exp 00a0/1234", k, mem_adr, mem_wdata);
      end
      n_run++;
      if ({ack1, ack0, gnt} !== {(k == 3), 1'b0, 2'b10}) begin
        n_fail++; $display("FAIL write_ack k=%0d got %b exp %b", k, {ack1, ack0, gnt}, {(k == 3), 1'b0, 2'b10});
      end
      n_run++;
      if (rdata0 !== 16'hBEEF) begin n_fail++; $display("FAIL write_rdata0_hold got %h exp beef", rdata0); end
    end
    req1 = 0; wr1 = 0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    exp_t e;
    int acks, last, p;
    do_reset();
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      sb.push_back('{0, mem_fn(16'h0010)});
`else
      if (i % 2 == 0) sb.push_back('{0, mem_fn(16'h0010)});
      else            sb.push_back('{1, mem_fn(16'h0020)});
`endif
    end
    req0 = 1; rd0 = 1; wr0 = 0; adr0 = 16'h0010;
    req1 = 1; rd1 = 1; wr1 = 0; adr1 = 16'h0020;
    last = cyc;
    acks = 0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        n_run++;
        if (ack0 && ack1) begin n_fail++; $display("FAIL cont_both_ack got 11 exp one-hot"); end
        n_run++;
        if (cyc - last != ((acks == 0) ? 3 : 4)) begin
          n_fail++; $display("FAIL cont_spacing ack=%0d got %0d exp %0d", acks, cyc - last, (acks == 0) ? 3 : 4);
        end
        last = cyc;
        n_run++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL cont_sb empty queue"); end
        else begin
          e = sb.pop_front();
          if (p != e.port || (p ? rdata1 : rdata0) !== e.rdata) begin
            n_fail++; $display("FAIL cont_order ack=%0d got port %0d data %h exp port %0d data %h",
                               acks, p, p ? rdata1 : rdata0, e.port, e.rdata);
          end
        end
        acks++;
      end
    end
    req0 = 0; rd0 = 0; req1 = 0; rd1 = 0;
    n_run++;
    if (acks != 4) begin n_fail++; $display("FAIL cont_timeout got %0d acks exp 4", acks); sb.delete(); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_corner();
    logic [15:0] hold;
    hold = mem_fn(16'h0010);
    @(negedge clk);
    req0 = 1; rd0 = 1; wr0 = 1; adr0 = 16'h0030; wdata0 = 16'h5555;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_run++;
      if ({mem_rd, mem_wr, mem_oe, ack0} !== {1'b0, (k < 3), (k < 3), (k == 3)}) begin
        n_fail++; $display("FAIL rdwr k=%0d got %b exp %b", k, {mem_rd, mem_wr, mem_oe, ack0}, {1'b0, (k < 3), (k < 3), (k == 3)});
      end
    end
    n_run++;
    if (rdata0 !== hold) begin n_fail++; $display("FAIL rdwr_rdata0 got %h exp %h", rdata0, hold); end
    req0 = 0; rd0 = 0; wr0 = 0;
    @(negedge clk);
    req0 = 1; rd0 = 0; wr0 = 0; adr0 = 16'h0040;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_run++;
      if ({mem_rd, mem_wr, mem_oe, busy, ack0} !== {3'b000, 1'b1, (k == 3)}) begin
        n_fail++; $display("FAIL null k=%0d got %b exp %b", k, {mem_rd, mem_wr, mem_oe, busy, ack0}, {3'b000, 1'b1, (k == 3)});
      end
    end
    n_run++;
    if (rdata0 !== hold) begin n_fail++; $display("FAIL null_rdata0 got %h exp %h", rdata0, hold); end
    req0 = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge clk);
    req1 = 1; wr1 = 1; rd1 = 0; adr1 = 16'h00C0; wdata1 = 16'hCAFE;
    @(negedge clk);
    n_run++;
    if (mem_wr !== 1'b1) begin n_fail++; $display("FAIL rmid_access got %b exp 1", mem_wr); end
    reset = 1; req1 = 0; wr1 = 0;
    @(negedge clk);
    n_run++;
    if ({mem_wr, mem_oe, gnt, busy, ack1} !== 6'b0 || mem_adr !== 16'h0) begin
      n_fail++; $display("FAIL rmid_reset got %b adr %h exp 0", {mem_wr, mem_oe, gnt, busy, ack1}, mem_adr);
    end
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_run++;
      if ({ack0, ack1} !== 2'b00) begin n_fail++; $display("FAIL rmid_noack k=%0d got %b exp 00", k, {ack0, ack1}); end
    end
    req0 = 1; rd0 = 1; adr0 = 16'h0040;
    req1 = 1; rd1 = 1; adr1 = 16'h0020;
    sb.push_back('{0, 16'hBEEF});
    @(negedge clk);
    n_run++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL rmid_winner got %b exp 01", gnt); end
    req1 = 0; rd1 = 0;
    repeat (2) @(negedge clk);
    n_run++;
    if (ack0 !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL rmid_ack0 got %b exp 1", ack0);
    end else begin
      e = sb.pop_front();
      if (rdata0 !== e.rdata) begin n_fail++; $display("FAIL rmid_rdata0 got %h exp %h", rdata0, e.rdata); end
    end
    req0 = 0; rd0 = 0;
    sb.delete();
    @(negedge clk);
  endtask

  task automatic test_zero_wait();
    exp_t e;
    @(negedge clk);
    z_req0 = 1; z_rd0 = 1; z_adr0 = 16'h0040;
    sb.push_back('{0, 16'hBEEF});
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      n_run++;
      if ({z_mem_rd, z_ack0, z_gnt} !== {(k == 1), (k == 2), 2'b01}) begin
        n_fail++; $display("FAIL zws k=%0d got %b exp %b", k, {z_mem_rd, z_ack0, z_gnt}, {(k == 1), (k == 2), 2'b01});
      end
    end
    n_run++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL zws_sb empty queue"); end
    else begin
      e = sb.pop_front();
      if (z_rdata0 !== e.rdata) begin n_fail++; $display("FAIL zws_rdata0 got %h exp %h", z_rdata0, e.rdata); end
    end
    z_req0 = 0; z_rd0 = 0;
    @(negedge clk);
    n_run++;
    if (z_busy !== 1'b0) begin n_fail++; $display("FAIL zws_idle got %b exp 0", z_busy); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_corner();
    test_reset_mid();
    test_zero_wait();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog run did not complete");
    $fatal(1);
  end

endmodule
